// File: rtl/wb_arbiter_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : wb_arbiter_scoreboard
// Description : Round-robin writeback arbiter (ALU / LSU) onto the register
//               bank write port, with a per-register RAW busy scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module wb_arbiter_scoreboard #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_rd,
  input  logic [DATA_W-1:0] alu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [ADDR_W-1:0] lsu_rd,
  input  logic [DATA_W-1:0] lsu_data,
  input  logic              issue_valid,
  input  logic [ADDR_W-1:0] issue_rd,
  input  logic              flush,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic              rs1_busy,
  output logic              rs2_busy,
  output logic              wb_we,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data
);

  localparam int unsigned c_NUM_REGS = 2 ** ADDR_W;

  typedef enum logic [0:0] {
    GRANT_ALU = 1'b0,
    GRANT_LSU = 1'b1
  } grant_t;

  grant_t              r_last_grant;
  grant_t              w_next_grant;
  logic                w_alu_ready;
  logic                w_lsu_ready;
  logic                w_alu_xfer;
  logic                w_lsu_xfer;
  logic                r_wb_we;
  logic [ADDR_W-1:0]   r_wb_addr;
  logic [DATA_W-1:0]   r_wb_data;
  logic [c_NUM_REGS-1:0] r_busy;
  logic [c_NUM_REGS-1:0] w_busy_next;

  // Readiness depends only on the other requester, never on the own valid.
  assign w_alu_ready = !lsu_valid || (r_last_grant == GRANT_LSU);
  assign w_lsu_ready = !alu_valid || (r_last_grant == GRANT_ALU);
  assign w_alu_xfer  = alu_valid && w_alu_ready;
  assign w_lsu_xfer  = lsu_valid && w_lsu_ready;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_last_grant <= GRANT_LSU;
    end else begin
      r_last_grant <= w_next_grant;
    end
  end

  always_comb begin
    w_next_grant = r_last_grant;
    if (w_alu_xfer) begin
      w_next_grant = GRANT_ALU;
    end else if (w_lsu_xfer) begin
      w_next_grant = GRANT_LSU;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wb_we   <= 1'b0;
      r_wb_addr <= '0;
      r_wb_data <= '0;
    end else if (w_alu_xfer) begin
      r_wb_we   <= (alu_rd != '0);
      r_wb_addr <= alu_rd;
      r_wb_data <= alu_data;
    end else if (w_lsu_xfer) begin
      r_wb_we   <= (lsu_rd != '0);
      r_wb_addr <= lsu_rd;
      r_wb_data <= lsu_data;
    end else begin
      r_wb_we   <= 1'b0;
    end
  end

  // Priority low to high: clear on commit, set on issue, flush, x0 pinned.
  always_comb begin
    w_busy_next = r_busy;
    if (r_wb_we) begin
      w_busy_next[r_wb_addr] = 1'b0;
    end
    if (issue_valid) begin
      w_busy_next[issue_rd] = 1'b1;
    end
    if (flush) begin
      w_busy_next = '0;
    end
    w_busy_next[0] = 1'b0;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busy_next;
    end
  end

  assign alu_ready = w_alu_ready;
  assign lsu_ready = w_lsu_ready;
  assign rs1_busy  = r_busy[rs1_addr];
  assign rs2_busy  = r_busy[rs2_addr];
  assign wb_we     = r_wb_we;
  assign wb_addr   = r_wb_addr;
  assign wb_data   = r_wb_data;

endmodule
`default_nettype wire

// File: tb/tb_wb_arbiter_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_wb_arbiter_scoreboard
// Description : Directed vector bench for wb_arbiter_scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_arbiter_scoreboard;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        alu_valid = 1'b0, lsu_valid = 1'b0, issue_valid = 1'b0, flush = 1'b0;
  logic [4:0]  alu_rd = '0, lsu_rd = '0, issue_rd = '0, rs1_addr = '0, rs2_addr = '0;
  logic [31:0] alu_data = '0, lsu_data = '0;
  logic        alu_ready, lsu_ready, rs1_busy, rs2_busy, wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  wb_arbiter_scoreboard #(.DATA_W(32), .ADDR_W(5)) dut (
    .clock(clock), .reset(reset),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .issue_valid(issue_valid), .issue_rd(issue_rd), .flush(flush),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_busy(rs1_busy), .rs2_busy(rs2_busy),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data)
  );

  typedef struct {
    string       name;
    logic        av;  logic [4:0] ard; logic [31:0] ad;
    logic        lv;  logic [4:0] lrd; logic [31:0] ld;
    logic        iv;  logic [4:0] ird; logic fl;
    logic [4:0]  r1;  logic [4:0] r2;
    logic        e_ar; logic e_lr; logic e_b1; logic e_b2;
    logic        e_we; logic [4:0] e_addr; logic [31:0] e_data;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(string name,
      logic av, logic [4:0] ard, logic [31:0] ad,
      logic lv, logic [4:0] lrd, logic [31:0] ld,
      logic iv, logic [4:0] ird, logic fl, logic [4:0] r1, logic [4:0] r2,
      logic e_ar, logic e_lr, logic e_b1, logic e_b2,
      logic e_we, logic [4:0] e_addr, logic [31:0] e_data);
    vec_t v;
    v.name = name; v.av = av; v.ard = ard; v.ad = ad; v.lv = lv; v.lrd = lrd; v.ld = ld;
    v.iv = iv; v.ird = ird; v.fl = fl; v.r1 = r1; v.r2 = r2;
    v.e_ar = e_ar; v.e_lr = e_lr; v.e_b1 = e_b1; v.e_b2 = e_b2;
    v.e_we = e_we; v.e_addr = e_addr; v.e_data = e_data;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    alu_valid = v.av; alu_rd = v.ard; alu_data = v.ad;
    lsu_valid = v.lv; lsu_rd = v.lrd; lsu_data = v.ld;
    issue_valid = v.iv; issue_rd = v.ird; flush = v.fl;
    rs1_addr = v.r1; rs2_addr = v.r2;
  endtask

  task automatic idle();
    alu_valid = 1'b0; lsu_valid = 1'b0; issue_valid = 1'b0; flush = 1'b0;
  endtask

  initial begin
    //                 alu              lsu              issue     fl r1 r2  ar lr b1 b2  we addr data
    vecs.push_back(mk("tie0_alu1",  1,1,32'd1,  1,9,32'd9,   0,0,0, 0,0,  1,0,0,0, 1,1, 32'd1));
    vecs.push_back(mk("tie1_lsu9",  1,2,32'd2,  1,9,32'd9,   0,0,0, 0,0,  0,1,0,0, 1,9, 32'd9));
    vecs.push_back(mk("tie2_alu2",  1,2,32'd2,  1,10,32'd10, 0,0,0, 0,0,  1,0,0,0, 1,2, 32'd2));
    vecs.push_back(mk("tie3_lsu10", 1,3,32'd3,  1,10,32'd10, 0,0,0, 0,0,  0,1,0,0, 1,10,32'd10));
    vecs.push_back(mk("alu_single", 1,5,32'hDEADBEEF, 0,0,0, 0,0,0, 5,0,  1,0,0,0, 1,5, 32'hDEADBEEF));
    vecs.push_back(mk("alu_after",  0,0,0,      0,0,0,       0,0,0, 5,0,  1,1,0,0, 0,5, 32'hDEADBEEF));
    vecs.push_back(mk("x0_lsu",     0,0,0,      1,0,32'h1234,0,0,0, 0,0,  0,1,0,0, 0,0, 32'h1234));
    vecs.push_back(mk("x0_after",   0,0,0,      0,0,0,       0,0,0, 0,0,  1,1,0,0, 0,0, 32'h1234));
    vecs.push_back(mk("sb_issue7",  0,0,0,      0,0,0,       1,7,0, 7,7,  1,1,0,0, 0,0, 32'h1234));
    vecs.push_back(mk("sb_wait1",   0,0,0,      0,0,0,       0,0,0, 7,0,  1,1,1,0, 0,0, 32'h1234));
    vecs.push_back(mk("sb_wait2",   0,0,0,      0,0,0,       0,0,0, 7,0,  1,1,1,0, 0,0, 32'h1234));
    vecs.push_back(mk("sb_lsu7",    0,0,0,      1,7,32'h77,  0,0,0, 7,0,  1,1,1,0, 1,7, 32'h77));
    vecs.push_back(mk("sb_commit7", 0,0,0,      0,0,0,       0,0,0, 0,7,  1,1,0,1, 0,7, 32'h77));
    vecs.push_back(mk("sb_clear7",  0,0,0,      0,0,0,       0,0,0, 7,7,  1,1,0,0, 0,7, 32'h77));
    vecs.push_back(mk("sc_issue3",  0,0,0,      0,0,0,       1,3,0, 3,0,  1,1,0,0, 0,7, 32'h77));
    vecs.push_back(mk("sc_alu3",    1,3,32'h33, 0,0,0,       0,0,0, 3,0,  1,0,1,0, 1,3, 32'h33));
    vecs.push_back(mk("sc_collide", 0,0,0,      0,0,0,       1,3,0, 3,0,  1,1,1,0, 0,3, 32'h33));
    vecs.push_back(mk("sc_hold3",   0,0,0,      0,0,0,       0,0,0, 3,0,  1,1,1,0, 0,3, 32'h33));
    vecs.push_back(mk("fl_issue8",  0,0,0,      0,0,0,       1,8,1, 8,3,  1,1,0,1, 0,3, 32'h33));
    vecs.push_back(mk("fl_after",   0,0,0,      0,0,0,       1,0,0, 8,3,  1,1,0,0, 0,3, 32'h33));
    vecs.push_back(mk("x0_issue",   0,0,0,      0,0,0,       0,0,0, 0,8,  1,1,0,0, 0,3, 32'h33));

    #1;
    chk("rst_wb_we",   {31'd0, wb_we}, 32'd0);
    chk("rst_wb_addr", {27'd0, wb_addr}, 32'd0);
    chk("rst_wb_data", wb_data, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;

    foreach (vecs[i]) begin
      if (i != 0) @(negedge clock);
      drive(vecs[i]);
      #1;
      chk({vecs[i].name, "_alu_ready"}, {31'd0, alu_ready}, {31'd0, vecs[i].e_ar});
      chk({vecs[i].name, "_lsu_ready"}, {31'd0, lsu_ready}, {31'd0, vecs[i].e_lr});
      chk({vecs[i].name, "_rs1_busy"},  {31'd0, rs1_busy},  {31'd0, vecs[i].e_b1});
      chk({vecs[i].name, "_rs2_busy"},  {31'd0, rs2_busy},  {31'd0, vecs[i].e_b2});
      @(posedge clock);
      #1;
      chk({vecs[i].name, "_wb_we"},   {31'd0, wb_we},   {31'd0, vecs[i].e_we});
      chk({vecs[i].name, "_wb_addr"}, {27'd0, wb_addr}, {27'd0, vecs[i].e_addr});
      chk({vecs[i].name, "_wb_data"}, wb_data, vecs[i].e_data);
    end

    // Async reset mid-cycle while a write is on the bank port.
    @(negedge clock);
    idle();
    issue_valid = 1'b1; issue_rd = 5'd6; rs1_addr = 5'd6;
    @(negedge clock);
    idle();
    alu_valid = 1'b1; alu_rd = 5'd6; alu_data = 32'h66;
    @(posedge clock);
    #1;
    chk("ar_pre_we",   {31'd0, wb_we}, 32'd1);
    chk("ar_pre_busy", {31'd0, rs1_busy}, 32'd1);
    alu_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("ar_wb_we",   {31'd0, wb_we}, 32'd0);
    chk("ar_wb_addr", {27'd0, wb_addr}, 32'd0);
    chk("ar_wb_data", wb_data, 32'd0);
    chk("ar_busy6",   {31'd0, rs1_busy}, 32'd0);

    // First tie after release goes to the ALU even though ALU won last.
    @(negedge clock);
    reset = 1'b1;
    alu_valid = 1'b1; alu_rd = 5'd11; alu_data = 32'hB;
    lsu_valid = 1'b1; lsu_rd = 5'd12; lsu_data = 32'hC;
    #1;
    chk("rel_alu_ready", {31'd0, alu_ready}, 32'd1);
    chk("rel_lsu_ready", {31'd0, lsu_ready}, 32'd0);
    @(posedge clock);
    #1;
    chk("rel_wb_we",   {31'd0, wb_we}, 32'd1);
    chk("rel_wb_addr", {27'd0, wb_addr}, 32'd11);
    @(negedge clock);
    idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/wb_arbiter_scoreboard.md
Name: wb_arbiter_scoreboard

Overview:
- Writeback stage directly upstream of the 32x32 RV32I register bank.
- Arbitrates results from two producers (single-cycle ALU, variable-latency load/store unit) onto the bank's single write port (write_enable / write_addr / Wdata_in).
- Keeps a per-register busy scoreboard so issue logic can stall RAW hazards until the bank holds the new value.

Parameters:
- DATA_W, 32, result/write data width.
- ADDR_W, 5, register address width (2**ADDR_W registers).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low.
- alu_valid  in  1  ALU result available.
- alu_ready  out  1  ALU result accepted this cycle when alu_valid high.
- alu_rd  in  ADDR_W  ALU destination register.
- alu_data  in  DATA_W  ALU result.
- lsu_valid  in  1  load result available.
- lsu_ready  out  1  load result accepted this cycle when lsu_valid high.
- lsu_rd  in  ADDR_W  load destination register.
- lsu_data  in  DATA_W  load data.
- issue_valid  in  1  instruction issued that will write issue_rd.
- issue_rd  in  ADDR_W  destination of the issued instruction.
- flush  in  1  synchronous scoreboard clear (pipeline flush).
- rs1_addr, rs2_addr  in  ADDR_W  operand addresses to check.
- rs1_busy, rs2_busy  out  1  operand has a write outstanding.
- wb_we  out  1  to register bank write_enable.
- wb_addr  out  ADDR_W  to register bank write_addr.
- wb_data  out  DATA_W  to register bank Wdata_in.

Behaviour:
- Reset (async, reset=0):
  - wb_we=0, wb_addr=0, wb_data=0.
  - busy[all]=0.
  - last_grant=LSU, so the ALU wins the first tie.
- Handshake: a transfer occurs on an edge where valid&&ready. At most one transfer per cycle.
- Ready is combinational:
  - alu_ready = !lsu_valid || last_grant==LSU.
  - lsu_ready = !alu_valid || last_grant==ALU.
  - With one source valid, that source is always ready.
  - Ready never depends on the requester's own valid.
- Round-robin:
  - last_grant updates only on a transfer, to the granted source.
  - Both valid every cycle: grants alternate ALU, LSU, ALU, ...
- Output register (latency 1):
  - On a transfer edge: wb_addr<=rd, wb_data<=data, wb_we<=(rd!=0).
  - Otherwise wb_we<=0, and wb_addr/wb_data hold.
  - The bank commits on the following edge, i.e. 2 edges after acceptance.
- x0: a transfer with rd=0 is consumed (ready/handshake normal) but never raises wb_we.
- Scoreboard busy[2**ADDR_W-1:0], updated at each edge:
  - Set: issue_valid && issue_rd!=0 sets busy[issue_rd].
  - Clear: wb_we==1 clears busy[wb_addr]. This is the same edge the bank writes, so once busy reads 0 the bank already holds the value.
  - Set and clear of the same register on the same edge: set wins.
  - flush=1: all bits cleared; flush beats a simultaneous issue (that issue is dropped). Outstanding output-register contents are still written to the bank.
  - busy[0] is constant 0.
- rsN_busy = busy[rsN_addr], combinational. No bypass: it stays 1 through the cycle wb_we is high for that register.
- WAW: one bit per register. Issue logic must not issue to a busy rd; behaviour when it does is undefined beyond "bit stays set until next clear".
- Mid-operation reset deassertion: the first edge after release behaves as from the reset state. An asserted valid is accepted normally.

Test Plan:
- Single ALU result: alu_valid=1, rd=5, data=0xDEADBEEF, lsu idle.
  - alu_ready=1 that cycle.
  - Next cycle wb_we=1, wb_addr=5, wb_data=0xDEADBEEF.
  - Following cycle wb_we=0.
- Contention: both valid for 4 cycles (ALU rd=1..4, LSU rd=9..12, data=rd).
  - Grants ALU1, LSU9, ALU2, LSU10.
  - Exactly one ready high per cycle.
  - wb_addr sequence 1, 9, 2, 10.
- x0 suppression: LSU rd=0, data=0x1234.
  - lsu_ready=1.
  - wb_we stays 0.
  - rs1_addr=0 gives rs1_busy=0 throughout.
- Scoreboard timing: issue rd=7 at edge T0; LSU delivers rd=7 at T3.
  - rs1_busy(7)=1 from after T0 through the cycle following T3.
  - wb_we high in cycle T3..T4.
  - busy drops after T4.
- Set/clear and flush collision:
  - wb_we commits rd=3 on the same edge as issue rd=3 → busy[3] remains 1.
  - flush with issue rd=8 on the same edge → all busy 0, including 8.
- Async reset: assert reset=0 mid-cycle while wb_we=1.
  - wb_we, wb_addr, wb_data and all busy bits go 0 immediately, without a clock edge.
  - After release, the first tie grants the ALU.
